sram22_masked_init: RTL and testbench
=====================================

SRAM22_MASKED_INIT -- requirements
Module: sram22_masked_init

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width; RAM_DEPTH = 1 << ADDR_WIDTH, not overridable.
REQ-003 SHALL have parameter WMASK_WIDTH, default 4, number of write lanes; lane width G = DATA_WIDTH / WMASK_WIDTH.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port en, input, 1, access enable.
REQ-007 SHALL have port we, input, 1, write enable (1 = write, 0 = read when en=1).
REQ-008 SHALL have port wmask, input, WMASK_WIDTH, per-lane write mask.
REQ-009 SHALL have port addr, input, ADDR_WIDTH, word address.
REQ-010 SHALL have port din, input, DATA_WIDTH, write data.
REQ-011 SHALL have port dout, output, DATA_WIDTH, registered read data.
REQ-012 SHALL have port dout_valid, output, 1, one-cycle pulse marking new dout.
REQ-013 SHALL have port ready, output, 1, high once the post-reset clear sweep is complete.

Function
REQ-014 SHALL fail elaboration with an error if DATA_WIDTH % WMASK_WIDTH != 0.
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR, SHALL write all-zero to mem[clr_cnt] each cycle; clr_cnt is ADDR_WIDTH wide and increments by 1.
REQ-017 SHALL go CLEAR -> READY in the cycle after the write to address RAM_DEPTH-1; ready rises with the READY state, exactly RAM_DEPTH cycles after rst deasserts.
REQ-018 While ready=0, SHALL ignore en/we/addr/din/wmask: no memory update, dout_valid=0.
REQ-019 In READY, en=1 and we=1 SHALL update, for each lane i with wmask[i]=1, bits [i*G +: G] of mem[addr] from din; lanes with wmask[i]=0 stay unchanged.
REQ-020 A write with wmask all zero SHALL leave memory unchanged and otherwise behave as a write.
REQ-021 On a write cycle, dout SHALL hold its previous value (never X), and no dout_valid pulse SHALL be produced for it.
REQ-022 In READY, en=1 and we=0 SHALL load dout with mem[addr] at the next edge and pulse dout_valid=1 for one cycle (latency 1).
REQ-023 A read in the cycle after a write to the same address SHALL return the merged post-write word.
REQ-024 en=0 SHALL perform no access; dout holds and dout_valid=0.
REQ-025 Back-to-back reads SHALL sustain one result per cycle; dout_valid stays high across them.

Reset
REQ-026 rst=1 SHALL force state CLEAR, clr_cnt=0, ready=0, dout=0, dout_valid=0, and clear any pipelined read.
REQ-027 While rst is held, clr_cnt SHALL stay 0 and the memory SHALL not be written.
REQ-028 rst asserted mid-sweep or in READY SHALL abort the current activity and restart the full sweep from address 0 after deassertion.

Configuration
REQ-029 Macro SRAM22_OUTPUT_REG_EN SHALL control an extra output register stage.
REQ-030 With SRAM22_OUTPUT_REG_EN defined, read latency SHALL be 2 cycles, with dout_valid delayed identically; throughput stays 1 read per cycle; a write cycle neither stalls nor corrupts an in-flight read; the extra stage resets to 0.
REQ-031 With SRAM22_OUTPUT_REG_EN undefined, read latency SHALL be 1 cycle as in REQ-022.

Verification (DATA_WIDTH=32, ADDR_WIDTH=9, WMASK_WIDTH=4)
REQ-032 Pulse rst for 1 cycle -> ready=0 for 512 cycles, then 1; reads of addresses 0..511 all return 0x00000000 with dout_valid pulses.
REQ-033 Write 0x1A5 <= 0xDEADBEEF with wmask 4'b1111, then write 0x11223344 with wmask 4'b0101, then read 0x1A5 -> dout=0xDE22BE44 one cycle later (two with the macro).
REQ-034 Write 0x003 <= 0xCAFEF00D during cycle 10 of the clear sweep; after ready, read 0x003 -> 0x00000000.
REQ-035 Assert rst at sweep cycle 200 -> ready stays 0 for a further 512 cycles after deassertion; a prior write of 0x12345678 to 0x0FF reads back 0 afterwards.
REQ-036 Read 0x010, then write 0x010 <= 0xFFFFFFFF (mask 4'b1000), then read 0x010 -> first dout=0, dout held during the write cycle, second dout=0xFF000000.
REQ-037 Run the same read-stream with and without SRAM22_OUTPUT_REG_EN -> identical data sequence, valid offset by exactly one cycle.

Source files
------------

// File: rtl/sram22_masked_init.sv
// sram22_masked_init: single-port SRAM with per-lane write mask and a
// post-reset clear sweep.
//
// After reset the array is swept from address 0 to RAM_DEPTH-1 writing
// zeros, one word per cycle; user accesses are ignored until the sweep
// finishes and `ready` rises. Reads are registered (latency 1).
//
// Optional build macro: SRAM22_OUTPUT_REG_EN
//   When defined, an extra output register is added after the array read
//   register, making read latency 2 cycles (dout_valid delayed to match).
module sram22_masked_init #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready
);

    // Depth is derived from the address width and deliberately not a
    // parameter, so the sweep always covers every addressable word.
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LANE_W    = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    // Lanes must tile the word exactly; a remainder would leave bits that
    // no mask bit controls.
    generate
        if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_lane_split
            $error("sram22_masked_init: DATA_WIDTH must be a multiple of WMASK_WIDTH");
        end
    endgenerate

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

    // Decoded per-cycle actions
    logic                    clear_we;   // sweep writes zero this cycle
    logic                    acc_wr;     // user write accepted
    logic                    acc_rd;     // user read accepted

    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   rd_data;    // concatenated lane read registers
    logic                    rd_valid_q;

    // State and sweep counter registers; reset restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic and access decode. The explicit !rst terms keep the
    // array untouched while reset is held, not just the state registers.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clear_we  = 1'b0;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clear_we  = !rst;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                // The last word is written on this edge; the counter wraps
                // back to 0 as the FSM enters READY.
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                acc_wr = en && we && !rst;
                acc_rd = en && !we && !rst;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // The sweep owns the write port while clearing; users never see it.
    assign mem_waddr = clear_we ? clr_cnt_q : addr;

    // One narrow memory per lane so each lane infers a plain block RAM with
    // its own write enable; masking becomes per-lane enables.
    generate
        for (genvar gi = 0; gi < WMASK_WIDTH; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [RAM_DEPTH];
            logic              lane_we;
            logic [LANE_W-1:0] lane_wdata;
            logic [LANE_W-1:0] lane_rd_q;

            assign lane_we    = clear_we || (acc_wr && wmask[gi]);
            assign lane_wdata = clear_we ? '0 : din[gi*LANE_W +: LANE_W];

            // Array write port: sweep zeros or masked user data.
            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem[mem_waddr] <= lane_wdata;
                end
            end

            // Registered read; holds its value on writes and idle cycles so
            // dout never goes X after reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_rd_q <= '0;
                end else if (acc_rd) begin
                    lane_rd_q <= mem[addr];
                end
            end

            assign rd_data[gi*LANE_W +: LANE_W] = lane_rd_q;
        end
    endgenerate

    // Read-valid pulse aligned with the array read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= acc_rd;
        end
    end

`ifdef SRAM22_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    // Extra output stage: captures only fresh read data so intervening
    // write cycles neither stall nor disturb an in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= rd_data;
            end
        end
    end

    assign dout       = out_data_q;
    assign dout_valid = out_valid_q;
`else
    assign dout       = rd_data;
    assign dout_valid = rd_valid_q;
`endif

    assign ready = (state_q == S_READY);

endmodule

// File: tb/tb_sram22_masked_init.sv
// Testbench for sram22_masked_init (DATA_WIDTH=32, ADDR_WIDTH=9, WMASK_WIDTH=4).
// A word-level reference model (array + timed read queue) is updated on every
// clock edge and compared against ready/dout_valid/dout each cycle; directed
// steps add explicit checks for the documented scenarios.
module tb_sram22_masked_init;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int MW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM22_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          we;
    logic [MW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          ready;

    sram22_masked_init #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .wmask     (wmask),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] m_mem [DEPTH];
    rd_t         rdq[$];
    int          m_swept;     // words cleared since reset released
    bit          m_ready;
    logic [31:0] exp_dout;
    bit          exp_valid;
    int          ncyc;
    int          vcount;      // dout_valid pulses observed

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, ncyc);
        end
    endtask

    // One clock cycle: apply inputs, advance the model at the edge, compare.
    task automatic cycle(input logic e, input logic w, input logic [3:0] m,
                         input logic [8:0] a, input logic [31:0] d);
        en = e; we = w; wmask = m; addr = a; din = d;
        @(posedge clk);
        ncyc++;
        if (rst) begin
            m_swept   = 0;
            m_ready   = 0;
            rdq.delete();
            exp_dout  = '0;
            exp_valid = 0;
        end else begin
            if (!m_ready) begin
                m_mem[m_swept] = '0;
                m_swept++;
                if (m_swept == DEPTH) m_ready = 1;
            end else if (e) begin
                if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (m[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
                end else begin
                    rdq.push_back('{due: ncyc + LAT - 1, data: m_mem[a]});
                end
            end
            exp_valid = 0;
            if (rdq.size() > 0 && rdq[0].due == ncyc) begin
                exp_dout  = rdq[0].data;
                exp_valid = 1;
                void'(rdq.pop_front());
            end
        end
        #1;
        if (dout_valid === 1'b1) vcount++;
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, exp_valid});
        chk("dout", dout, exp_dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        cycle(1'b1, 1'b1, m, a, d);
    endtask

    task automatic rd(input logic [8:0] a);
        cycle(1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    task automatic junk();
        cycle(1'($urandom), 1'($urandom), 4'($urandom), 9'($urandom), $urandom);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        junk();
        rst = 1'b0;
    endtask

    // Run the sweep with random traffic (optionally a directed write at a
    // given sweep cycle) and check ready arrives after exactly DEPTH cycles.
    task automatic sweep(input string tag, input int wr_at, input logic [8:0] wa,
                         input logic [31:0] wd);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < DEPTH + 64) begin
            if (n == wr_at) wr(wa, wd, 4'hF);
            else junk();
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    task automatic read_expect(input string tag, input logic [8:0] a, input logic [31:0] expv);
        rd(a);
        idle(LAT - 1);
        chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
        chk(tag, dout, expv);
    endtask

    int v0;

    initial begin
        checks = 0; errors = 0; ncyc = 0; vcount = 0;
        m_swept = 0; m_ready = 0; exp_dout = '0; exp_valid = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        en = 0; we = 0; wmask = '0; addr = '0; din = '0;

        // Reset state, then a one-cycle reset pulse and the first sweep with
        // a write landing at sweep cycle 10 (must be ignored).
        rst = 1'b1;
        cycle(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        chk("reset_dout", dout, 32'h0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        pulse_rst();
        sweep("sweep_len_first", 10, 9'h003, 32'hCAFEF00D);

        // Every address reads zero, back to back, one valid per cycle.
        v0 = vcount;
        for (int i = 0; i < DEPTH; i++) rd(9'(i));
        idle(LAT);
        chk("full_read_pulses", vcount - v0, DEPTH);
        read_expect("ignored_sweep_write", 9'h003, 32'h0);

        // Masked merge.
        wr(9'h1A5, 32'hDEADBEEF, 4'b1111);
        wr(9'h1A5, 32'h11223344, 4'b0101);
        read_expect("masked_merge", 9'h1A5, 32'hDE22BE44);

        // Zero mask leaves memory untouched.
        wr(9'h1A5, 32'h55555555, 4'b0000);
        read_expect("zero_mask", 9'h1A5, 32'hDE22BE44);

        // Read, masked write, read of the same word.
        rd(9'h010);
        wr(9'h010, 32'hFFFFFFFF, 4'b1000);
        chk("hold_on_write", dout, 32'h0);
        rd(9'h010);
        idle(LAT - 1);
        chk("raw_after_write", dout, 32'hFF000000);
        idle(1);
        chk("hold_idle", dout, 32'hFF000000);

        // Random traffic over a small address window to hit read-after-write.
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
                  9'($urandom_range(0, 15)), $urandom);
        idle(LAT);

        // Reset mid-sweep: prior write to 0x0FF must read back zero.
        wr(9'h0FF, 32'h12345678, 4'hF);
        read_expect("pre_reset_word", 9'h0FF, 32'h12345678);
        pulse_rst();
        for (int i = 0; i < 200; i++) junk();
        chk("mid_sweep_not_ready", {31'd0, ready}, 32'd0);
        pulse_rst();
        sweep("sweep_len_restart", -1, 9'h0, 32'h0);
        read_expect("cleared_after_restart", 9'h0FF, 32'h0);

        // Reset with a read in flight drops it.
        wr(9'h020, 32'hA5A5A5A5, 4'hF);
        rd(9'h020);
        pulse_rst();
        chk("reset_kills_read_valid", {31'd0, dout_valid}, 32'd0);
        chk("reset_kills_read_dout", dout, 32'h0);
        sweep("sweep_len_ready_reset", -1, 9'h0, 32'h0);
        read_expect("cleared_after_ready_reset", 9'h020, 32'h0);

        // Read stream interleaved with writes to other addresses.
        for (int i = 0; i < 64; i++) begin
            if (i % 5 == 3) wr(9'(100 + i), $urandom, 4'($urandom));
            else rd(9'(100 + (i % 7)));
        end
        idle(LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
